// File: rtl/slv_reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// slv_reg_bank_pkg
//   Shared types and constants for the slave register bank.
//   - state_e    : request FSM states (IDLE / WAIT / RESP)
//   - ADDR_W     : register index width
//   - DATA_W     : register data width
//   - CNT_W      : wait counter / transaction counter width
//   - WPROT_ADDR : index that becomes read-only when SLV_REG_BANK_WPROT_EN
//                  is defined
//   - wait_load(): value loaded into the wait counter for a given
//                  WAIT_CYCLES setting
// ---------------------------------------------------------------------------
package slv_reg_bank_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;
  localparam int NREGS  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] WPROT_ADDR = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // The FSM spends WAIT_CYCLES cycles in WAIT, the last one with the
  // counter at zero, so the counter starts at WAIT_CYCLES-1.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned wc);
    return (wc == 0) ? '0 : CNT_W'(wc - 1);
  endfunction

endpackage

// File: rtl/slv_wait_cnt.sv
// ---------------------------------------------------------------------------
// slv_wait_cnt
//   Loadable down-counter that times the WAIT phase of a request.
//   Loading arms it for WAIT_CYCLES wait states; zero_o flags the final one.
//
//   Parameters:
//     WAIT_CYCLES : number of wait states to time (0..15)
//   Ports:
//     clk_i   in  clock
//     rst_ni  in  asynchronous active-low reset (counter -> 0)
//     load_i  in  arm the counter for a new request
//     dec_i   in  count down by one (holds at zero)
//     zero_o  out counter is zero
// ---------------------------------------------------------------------------
module slv_wait_cnt
  import slv_reg_bank_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = wait_load(WAIT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = LOAD_VAL;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/slv_reg_bank.sv
// ---------------------------------------------------------------------------
// slv_reg_bank
//   16 x 4-bit register bank behind a valid/ready slave port with a fixed
//   number of wait states. A request is captured in IDLE, waits WAIT_CYCLES
//   cycles, then completes with a one-cycle slv_ready strobe in RESP.
//
//   Parameters:
//     WAIT_CYCLES : wait states between capture and response (0..15)
//   Configuration macro:
//     SLV_REG_BANK_WPROT_EN : register 4'hF is read-only and reads back the
//                             transaction counter
//   Ports:
//     clock      in   clock, rising edge
//     reset_n    in   asynchronous active-low reset
//     slv_valid  in   request valid (held until slv_ready)
//     slv_write  in   1 = write, 0 = read
//     slv_addr   in   register index
//     slv_wdata  in   write data
//     slv_rdata  out  read data / write echo, zero outside RESP
//     slv_ready  out  one-cycle completion strobe
//     bus_out    out  {busy, txn_cnt[3:0]}
// ---------------------------------------------------------------------------
module slv_reg_bank
  import slv_reg_bank_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              slv_valid,
  input  logic              slv_write,
  input  logic [ADDR_W-1:0] slv_addr,
  input  logic [DATA_W-1:0] slv_wdata,
  output logic [DATA_W-1:0] slv_rdata,
  output logic              slv_ready,
  output logic [CNT_W:0]    bus_out
);

  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  state_e                         state_q;
  logic                           write_q;
  logic [ADDR_W-1:0]              addr_q;
  logic [DATA_W-1:0]              wdata_q;
  logic [NREGS-1:0][DATA_W-1:0]   regs_q;
  logic [CNT_W-1:0]               txn_cnt_q;
  logic                           busy_q;
  logic                           ready_q;
  logic [DATA_W-1:0]              rdata_q;

  logic              accept;
  logic              wait_zero;
  logic              go_resp;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] resp_data_d;
  logic              wr_allow;

  assign accept = (state_q == IDLE) && slv_valid;

  slv_wait_cnt #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .load_i (accept),
    .dec_i  (state_q == WAIT),
    .zero_o (wait_zero)
  );

  // With no wait states the response is computed in the capture cycle,
  // so the response mux looks at the live inputs while in IDLE.
  assign go_resp = (accept && NO_WAIT) || ((state_q == WAIT) && wait_zero);

  always_comb begin
    if (state_q == IDLE) begin
      sel_write = slv_write;
      sel_addr  = slv_addr;
      sel_wdata = slv_wdata;
    end else begin
      sel_write = write_q;
      sel_addr  = addr_q;
      sel_wdata = wdata_q;
    end
  end

  // Storage only changes at the end of RESP, so sampling it on the way into
  // RESP gives the value from before that response's own write.
  always_comb begin
    resp_data_d = regs_q[sel_addr];
    if (sel_write)
      resp_data_d = sel_wdata;
`ifdef SLV_REG_BANK_WPROT_EN
    else if (sel_addr == WPROT_ADDR)
      resp_data_d = txn_cnt_q;
`endif
  end

  always_comb begin
    wr_allow = write_q;
`ifdef SLV_REG_BANK_WPROT_EN
    if (addr_q == WPROT_ADDR) wr_allow = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      regs_q    <= '0;
      txn_cnt_q <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      if (go_resp) begin
        ready_q <= 1'b1;
        rdata_q <= resp_data_d;
      end
      case (state_q)
        IDLE: begin
          if (slv_valid) begin
            write_q <= slv_write;
            addr_q  <= slv_addr;
            wdata_q <= slv_wdata;
            busy_q  <= 1'b1;
            state_q <= NO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (wait_zero) state_q <= RESP;
        end
        RESP: begin
          if (wr_allow) regs_q[addr_q] <= wdata_q;
          txn_cnt_q <= txn_cnt_q + 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign slv_ready = ready_q;
  assign slv_rdata = rdata_q;
  assign bus_out   = {busy_q, txn_cnt_q};

endmodule

// File: tb/tb_slv_reg_bank.sv
module tb_slv_reg_bank;

`ifdef SLV_REG_BANK_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif
  localparam int WC = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  // instance with WAIT_CYCLES = 2
  logic       slv_valid = 1'b0, slv_write = 1'b0;
  logic [3:0] slv_addr = '0, slv_wdata = '0, slv_rdata;
  logic       slv_ready;
  logic [4:0] bus_out;
  // instance with WAIT_CYCLES = 0
  logic       v0 = 1'b0, w0 = 1'b0;
  logic [3:0] a0 = '0, d0 = '0, rd0;
  logic       rdy0;
  logic [4:0] bo0;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [3:0] m_mem [16];
  int         m_cnt;

  typedef struct {
    logic       w;
    logic [3:0] a;
    logic [3:0] d;
    logic [3:0] exp_rd;
    logic [3:0] exp_cnt;
  } vec_t;
  vec_t tbl [6];

  always #5 clock = ~clock;

  slv_reg_bank #(.WAIT_CYCLES(WC)) u_dut (
    .clock(clock), .reset_n(reset_n), .slv_valid(slv_valid), .slv_write(slv_write),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_rdata(slv_rdata),
    .slv_ready(slv_ready), .bus_out(bus_out)
  );

  slv_reg_bank #(.WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .slv_valid(v0), .slv_write(w0),
    .slv_addr(a0), .slv_wdata(d0), .slv_rdata(rd0),
    .slv_ready(rdy0), .bus_out(bo0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 4'h0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n   = 1'b0;
    slv_valid = 1'b0;
    v0        = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One full request on u_dut, checked against the model. With scr set the
  // request inputs are scrambled during WAIT.
  task automatic txn(input logic w, input logic [3:0] a, input logic [3:0] d,
                     input bit scr, output logic [3:0] rd);
    int         lat;
    bit         got;
    logic [3:0] exp;
    @(negedge clock);
    slv_valid = 1'b1; slv_write = w; slv_addr = a; slv_wdata = d;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (slv_ready) got = 1'b1;
      else begin
        chk("bus_wait", bus_out, {1'b1, 4'(m_cnt)});
        chk("rdata_wait", slv_rdata, 4'h0);
        if (scr) begin
          slv_write = 1'($urandom); slv_addr = 4'($urandom); slv_wdata = 4'($urandom);
        end
      end
    end
    chk("latency", lat, WC + 1);
    rd = slv_rdata;
    if (w)                   exp = d;
    else if (WPROT && a == 4'hF) exp = 4'(m_cnt);
    else                     exp = m_mem[a];
    chk("rdata_resp", rd, exp);
    chk("busy_resp", bus_out[4], 1'b1);
    if (w && !(WPROT && a == 4'hF)) m_mem[a] = d;
    m_cnt = (m_cnt + 1) % 16;
    slv_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("ready_after", slv_ready, 1'b0);
    chk("rdata_after", slv_rdata, 4'h0);
    chk("bus_idle", bus_out, {1'b0, 4'(m_cnt)});
  endtask

  initial begin
    logic [3:0] rd;
    model_reset();

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_bus", bus_out, 5'h00);
    chk("rst_ready", slv_ready, 1'b0);
    chk("rst_rdata", slv_rdata, 4'h0);
    chk("rst_bus0", bo0, 5'h00);
    reset_n = 1'b1;

    // directed vector table
    tbl[0] = '{w:1'b1, a:4'h3, d:4'hA, exp_rd:4'hA, exp_cnt:4'd1};
    tbl[1] = '{w:1'b0, a:4'h3, d:4'h0, exp_rd:4'hA, exp_cnt:4'd2};
    tbl[2] = '{w:1'b1, a:4'h0, d:4'h5, exp_rd:4'h5, exp_cnt:4'd3};
    tbl[3] = '{w:1'b1, a:4'hF, d:4'h7, exp_rd:4'h7, exp_cnt:4'd4};
    tbl[4] = '{w:1'b0, a:4'hF, d:4'h0, exp_rd:(WPROT ? 4'h4 : 4'h7), exp_cnt:4'd5};
    tbl[5] = '{w:1'b0, a:4'h0, d:4'h0, exp_rd:4'h5, exp_cnt:4'd6};
    for (int i = 0; i < 6; i++) begin
      txn(tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, rd);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_cnt", i), bus_out[3:0], tbl[i].exp_cnt);
    end

    // inputs changed during WAIT must not disturb the captured request
    txn(1'b1, 4'h2, 4'hC, 1'b1, rd);
    chk("scr_echo", rd, 4'hC);
    txn(1'b0, 4'h2, 4'h0, 1'b1, rd);
    chk("scr_read", rd, 4'hC);

    // randomized traffic against the model
    for (int i = 0; i < 40; i++)
      txn(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), rd);

    // reset asserted during WAIT of a write to addr 5
    do_reset();
    txn(1'b1, 4'h5, 4'h3, 1'b0, rd);
    @(negedge clock);
    slv_valid = 1'b1; slv_write = 1'b1; slv_addr = 4'h5; slv_wdata = 4'h9;
    @(posedge clock);
    @(negedge clock);
    chk("rstw_busy", bus_out, 5'h11);
    #1 reset_n = 1'b0;
    #1;
    chk("rstw_bus", bus_out, 5'h00);
    chk("rstw_ready", slv_ready, 1'b0);
    slv_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rstw_noready", slv_ready, 1'b0);
    end
    reset_n = 1'b1;
    model_reset();
    @(negedge clock);
    chk("rstw_cnt", bus_out, 5'h00);
    txn(1'b0, 4'h5, 4'h0, 1'b0, rd);
    chk("rstw_reg5", rd, 4'h0);

    // txn_cnt wrap: 17 transactions then the 18th
    do_reset();
    for (int i = 0; i < 17; i++)
      txn(1'($urandom), 4'($urandom), 4'($urandom), 1'b0, rd);
    chk("wrap_cnt", bus_out, 5'b0_0001);
    txn(1'b0, 4'h1, 4'h0, 1'b0, rd);

    // WAIT_CYCLES = 0 instance: valid held for 4 back-to-back reads
    do_reset();
    @(negedge clock);
    v0 = 1'b1; w0 = 1'b0; a0 = 4'h1; d0 = 4'h0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("b2b_ready%0d", k), rdy0, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("b2b_busy%0d", k), bo0[4], (k % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("b2b_rdata%0d", k), rd0, 4'h0);
      if (k == 6) v0 = 1'b0;
    end
    chk("b2b_cnt", bo0, 5'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
